// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection among result producers (ALU, CSR,
// LSU), registered register-file write port, and a pending-exception holder
// that stalls all grants until trap logic acknowledges it.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int N_SRC = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_v,
    input  logic [N_SRC*XLEN-1:0]   src_result,
    input  logic [N_SRC*5-1:0]      src_rd,
    input  logic [N_SRC-1:0]        src_exc,
    output logic [N_SRC-1:0]        src_ok,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    retire,
    output logic                    exc_v,
    output logic [1:0]              exc_src,
    output logic [4:0]              exc_rd,
    input  logic                    exc_ack
);

    localparam int          PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned NS = N_SRC;

    typedef enum logic {
        RUN,
        EXC
    } state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       rr_ptr;
    logic                gnt_any;
    int unsigned         gnt_num;
    int unsigned         idx;
    logic [N_SRC-1:0]    v_shift;
    logic [N_SRC*XLEN-1:0] res_shift;
    logic [N_SRC*5-1:0]  rd_shift;
    logic [N_SRC-1:0]    exc_shift;
    logic [XLEN-1:0]     sel_result;
    logic [4:0]          sel_rd;
    logic                sel_exc;
    logic [PW-1:0]       ptr_nx;

    assign exc_v = (state == EXC);

    // Round-robin grant: first valid source at or after rr_ptr, only from
    // src_v and state so no data inputs feed the accept path.
    always_comb begin
        gnt_any = 1'b0;
        gnt_num = 0;
        idx     = 0;
        v_shift = '0;
        src_ok  = '0;
        if (!rst_n && state == RUN) begin
            for (int unsigned off = 0; off < NS; off++) begin
                idx = 32'(rr_ptr) + off;
                if (idx >= NS) idx = idx - NS;
                v_shift = src_v >> idx;
                if (!gnt_any && v_shift[0]) begin
                    gnt_any = 1'b1;
                    gnt_num = idx;
                end
            end
            if (gnt_any) src_ok = N_SRC'(1) << gnt_num;
        end
    end

    // Select the granted source's payload.
    always_comb begin
        res_shift  = src_result >> (gnt_num * 32'(XLEN));
        rd_shift   = src_rd >> (gnt_num * 32'd5);
        exc_shift  = src_exc >> gnt_num;
        sel_result = res_shift[XLEN-1:0];
        sel_rd     = rd_shift[4:0];
        sel_exc    = exc_shift[0];
        ptr_nx     = (gnt_num + 1 >= NS) ? '0 : PW'(gnt_num + 1);
    end

    // Next state: an excepting transfer parks the arbiter until acknowledged.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (gnt_any && sel_exc) state_nx = EXC;
            EXC:     if (exc_ack)            state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= RUN;
        else       state <= state_nx;
    end

    // Registered writeback, retire pulse, exception capture and pointer advance.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retire   <= 1'b0;
            exc_src  <= '0;
            exc_rd   <= '0;
            rr_ptr   <= '0;
        end else begin
            rf_we  <= gnt_any && !sel_exc && (sel_rd != '0);
            retire <= gnt_any && !sel_exc;
            if (gnt_any && !sel_exc && (sel_rd != '0)) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_result;
            end
            if (gnt_any && sel_exc) begin
                exc_src <= 2'(gnt_num);
                exc_rd  <= sel_rd;
            end
            if (gnt_any) rr_ptr <= ptr_nx;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int N    = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          src_v = '0;
    logic [N*XLEN-1:0]     src_result = '0;
    logic [N*5-1:0]        src_rd = '0;
    logic [N-1:0]          src_exc = '0;
    logic [N-1:0]          src_ok;
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  retire;
    logic                  exc_v;
    logic [1:0]            exc_src;
    logic [4:0]            exc_rd;
    logic                  exc_ack = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    wb_arbiter #(.XLEN(XLEN), .N_SRC(N)) dut (
        .clk(clk), .rst_n(rst_n), .src_v(src_v), .src_result(src_result),
        .src_rd(src_rd), .src_exc(src_exc), .src_ok(src_ok), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire),
        .exc_v(exc_v), .exc_src(exc_src), .exc_rd(exc_rd), .exc_ack(exc_ack)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int              m_ptr = 0;
    bit              m_exc_v = 0;
    int              m_exc_src = 0;
    int              m_exc_rd = 0;
    bit              m_we = 0;
    bit              m_retire = 0;
    logic [4:0]      m_waddr = '0;
    logic [XLEN-1:0] m_wdata = '0;

    function automatic int exp_grant();
        if (rst_n || m_exc_v) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (src_v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge (reset acts immediately).
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_ptr = 0; m_exc_v = 0; m_exc_src = 0; m_exc_rd = 0;
            m_we = 0; m_retire = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            int g;
            g = exp_grant();
            m_we = 0;
            m_retire = 0;
            if (m_exc_v) begin
                if (exc_ack) m_exc_v = 0;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (src_exc[g]) begin
                    m_exc_v = 1;
                    m_exc_src = g;
                    m_exc_rd = int'(src_rd[g*5 +: 5]);
                end else begin
                    m_retire = 1;
                    if (src_rd[g*5 +: 5] != 5'd0) begin
                        m_we = 1;
                        m_waddr = src_rd[g*5 +: 5];
                        m_wdata = src_result[g*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            int g;
            logic [N-1:0] eok;
            g = exp_grant();
            eok = (g < 0) ? '0 : N'(1) << g;
            chk("src_ok", 64'(src_ok), 64'(eok));
            chk("rf_we", 64'(rf_we), 64'(m_we));
            chk("retire", 64'(retire), 64'(m_retire));
            chk("exc_v", 64'(exc_v), 64'(m_exc_v));
            if (m_exc_v) begin
                chk("exc_src", 64'(exc_src), 64'(m_exc_src));
                chk("exc_rd", 64'(exc_rd), 64'(m_exc_rd));
            end
            if (m_we) begin
                chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
                chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [XLEN-1:0] res,
                           input logic [4:0] rd, input logic exc);
        src_v[i] = v;
        src_result[i*XLEN +: XLEN] = res;
        src_rd[i*5 +: 5] = rd;
        src_exc[i] = exc;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        src_v = '0; src_exc = '0; exc_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        int order[6];
        order = '{0, 1, 2, 0, 1, 2};
        rst_n = 1'b1;
        tick();
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_exc_v", 64'(exc_v), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_src_ok", 64'(src_ok), 64'd0);
        started = 1;

        // Single write from source 1
        do_reset();
        set_src(1, 1'b1, 32'hDEADBEEF, 5'd5, 1'b0);
        @(negedge clk);
        chk("d1_src_ok", 64'(src_ok), 64'b010);
        tick();
        src_v = '0;
        chk("d1_we", 64'(rf_we), 64'd1);
        chk("d1_waddr", 64'(rf_waddr), 64'd5);
        chk("d1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("d1_retire", 64'(retire), 64'd1);
        tick();
        chk("d1_idle_we", 64'(rf_we), 64'd0);
        chk("d1_idle_ret", 64'(retire), 64'd0);

        // Round robin with all sources valid
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 32'(100 + i), 5'(i + 1), 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("d2_grant", 64'(src_ok), 64'(1 << order[c]));
            tick();
            chk("d2_we", 64'(rf_we), 64'd1);
            chk("d2_waddr", 64'(rf_waddr), 64'(order[c] + 1));
        end

        // rd=0 retires without writing
        do_reset();
        set_src(0, 1'b1, 32'h1234, 5'd0, 1'b0);
        tick();
        src_v = '0;
        chk("d3_we", 64'(rf_we), 64'd0);
        chk("d3_retire", 64'(retire), 64'd1);

        // Exception from source 2, stall, acknowledge
        do_reset();
        set_src(2, 1'b1, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        chk("d4_grant", 64'(src_ok), 64'b100);
        tick();
        set_src(2, 1'b0, 32'h0, 5'd0, 1'b0);
        set_src(0, 1'b1, 32'h55, 5'd9, 1'b0);
        chk("d4_exc_v", 64'(exc_v), 64'd1);
        chk("d4_exc_src", 64'(exc_src), 64'd2);
        chk("d4_exc_rd", 64'(exc_rd), 64'd7);
        chk("d4_retire", 64'(retire), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("d4_blocked", 64'(src_ok), 64'd0);
            tick();
            chk("d4_hold", 64'(exc_v), 64'd1);
        end
        exc_ack = 1'b1;
        @(negedge clk);
        chk("d4_ack_blocked", 64'(src_ok), 64'd0);
        tick();
        exc_ack = 1'b0;
        chk("d4_cleared", 64'(exc_v), 64'd0);
        @(negedge clk);
        chk("d4_resume", 64'(src_ok), 64'b001);
        tick();

        // Reset right after a transfer
        do_reset();
        set_src(0, 1'b1, 32'hA5, 5'd3, 1'b0);
        tick();
        src_v = '0;
        chk("d5_we_pre", 64'(rf_we), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("d5_we_rst", 64'(rf_we), 64'd0);
        chk("d5_ret_rst", 64'(retire), 64'd0);
        tick();
        rst_n = 1'b0;
        set_src(1, 1'b1, 32'h11, 5'd4, 1'b0);
        set_src(2, 1'b1, 32'h22, 5'd6, 1'b0);
        @(negedge clk);
        chk("d5_first", 64'(src_ok), 64'b010);
        tick();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(99) == 0);
            for (int i = 0; i < N; i++) begin
                logic [4:0] rd;
                rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
                set_src(i, 1'($urandom_range(1)), $urandom, rd, ($urandom_range(7) == 0));
            end
            exc_ack = ($urandom_range(2) == 0);
            tick();
        end
        rst_n = 1'b0;
        @(negedge clk);
        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
